// File: rtl/cal_fifo_pkg.sv
// Shared FIFO controller definitions: depth derivation, flag threshold defaults,
// the status flag bundle and small helpers.
package cal_fifo_pkg;

   localparam int unsigned DEF_ADDRWIDTH = 3;
   localparam int unsigned DEF_AFULL_TH  = 6;
   localparam int unsigned DEF_AEMPTY_TH = 2;

   typedef struct packed {
      logic full;
      logic empty;
      logic afull;
      logic aempty;
   } fifo_flags_t;

   localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

   function automatic int unsigned fifo_depth(input int unsigned aw);
      return 32'(1) << aw;
   endfunction

   // Thresholds must fit the RAM and leave a gap between the two watermarks.
   function automatic bit fifo_params_ok(input int unsigned aw,
                                         input int unsigned afull_th,
                                         input int unsigned aempty_th);
      return (afull_th <= fifo_depth(aw)) && (aempty_th < afull_th);
   endfunction

   function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/cal_fifo_gray_ptr.sv
// Wrapping binary pointer with a registered Gray-coded copy that updates in the
// same cycle as the binary value.
module cal_fifo_gray_ptr
   import cal_fifo_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   output logic [W-1:0] bin_o,
   output logic [W-1:0] gray_o
);

   logic [W-1:0] bin_q, bin_d;
   logic [W-1:0] gray_q, gray_d;

   always_comb begin
      bin_d = bin_q;
      if (en_i) begin
         bin_d = bin_q + W'(1);
      end
      gray_d = W'(bin_to_gray(32'(bin_d)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q  <= '0;
         gray_q <= '0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
      end
   end

   assign bin_o  = bin_q;
   assign gray_o = gray_q;

endmodule

// File: rtl/cal_fifo_ctrl.sv
// Single-clock FIFO controller for an external RAM with one-cycle read latency:
// accept/reject logic, occupancy, registered status flags and error pulses.
module cal_fifo_ctrl
   import cal_fifo_pkg::*;
#(
   parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH,
   parameter int unsigned AFULL_TH  = DEF_AFULL_TH,
   parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic                 re,
   output logic                 mem_wen,
   output logic [ADDRWIDTH-1:0] mem_waddr,
   output logic                 mem_ren,
   output logic [ADDRWIDTH-1:0] mem_raddr,
   output logic                 rd_valid,
   output logic                 full,
   output logic                 empty,
   output logic                 afull,
   output logic                 aempty,
   output logic [ADDRWIDTH:0]   wrcnt,
   output logic [ADDRWIDTH:0]   wptr_gray,
   output logic [ADDRWIDTH:0]   rptr_gray,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int unsigned DEPTH = fifo_depth(ADDRWIDTH);
   localparam int unsigned PW    = ADDRWIDTH + 1;

   if (!fifo_params_ok(ADDRWIDTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
      $error("cal_fifo_ctrl: illegal thresholds AFULL_TH=%0d AEMPTY_TH=%0d DEPTH=%0d",
             AFULL_TH, AEMPTY_TH, DEPTH);
   end

   logic          wr_acc;
   logic          rd_acc;
   logic [PW-1:0] wbin;
   logic [PW-1:0] rbin;

   logic [PW-1:0] wrcnt_q,     wrcnt_d;
   fifo_flags_t   flags_q,     flags_d;
   logic          rd_valid_q,  rd_valid_d;
   logic          overflow_q,  overflow_d;
   logic          underflow_q, underflow_d;

   // Acceptance uses the flags registered at this edge; reset blocks all RAM traffic.
   assign wr_acc = we & ~flags_q.full  & ~reset;
   assign rd_acc = re & ~flags_q.empty & ~reset;

   cal_fifo_gray_ptr #(.W(PW)) u_wptr (
      .clk    (clk),
      .reset  (reset),
      .en_i   (wr_acc),
      .bin_o  (wbin),
      .gray_o (wptr_gray)
   );

   cal_fifo_gray_ptr #(.W(PW)) u_rptr (
      .clk    (clk),
      .reset  (reset),
      .en_i   (rd_acc),
      .bin_o  (rbin),
      .gray_o (rptr_gray)
   );

   // Pointer MSBs only distinguish laps; the RAM sees the low address bits.
   logic unused_ptr_msb;
   assign unused_ptr_msb = wbin[PW-1] ^ rbin[PW-1];

   always_comb begin
      wrcnt_d     = wrcnt_q;
      flags_d     = flags_q;
      rd_valid_d  = rd_acc;
      overflow_d  = we & flags_q.full;
      underflow_d = re & flags_q.empty;

      unique case ({wr_acc, rd_acc})
         2'b10:   wrcnt_d = wrcnt_q + PW'(1);
         2'b01:   wrcnt_d = wrcnt_q - PW'(1);
         default: wrcnt_d = wrcnt_q;
      endcase

      // Flags are derived from the next count so they land together with wrcnt.
      flags_d.full   = (wrcnt_d == PW'(DEPTH));
      flags_d.empty  = (wrcnt_d == '0);
      flags_d.afull  = (wrcnt_d >= PW'(AFULL_TH));
      flags_d.aempty = (wrcnt_d <= PW'(AEMPTY_TH));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrcnt_q     <= '0;
         flags_q     <= FLAGS_RESET;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrcnt_q     <= wrcnt_d;
         flags_q     <= flags_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign mem_wen   = wr_acc;
   assign mem_ren   = rd_acc;
   assign mem_waddr = wbin[ADDRWIDTH-1:0];
   assign mem_raddr = rbin[ADDRWIDTH-1:0];
   assign rd_valid  = rd_valid_q;
   assign full      = flags_q.full;
   assign empty     = flags_q.empty;
   assign afull     = flags_q.afull;
   assign aempty    = flags_q.aempty;
   assign wrcnt     = wrcnt_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_cal_fifo_ctrl.sv
// Self-checking bench for cal_fifo_ctrl: occupancy/pointer model plus directed
// scenarios with hand-computed expectations.
module tb_cal_fifo_ctrl;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       we;
   logic       re;
   logic       mem_wen;
   logic [2:0] mem_waddr;
   logic       mem_ren;
   logic [2:0] mem_raddr;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       afull;
   logic       aempty;
   logic [3:0] wrcnt;
   logic [3:0] wptr_gray;
   logic [3:0] rptr_gray;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   cal_fifo_ctrl #(.ADDRWIDTH(3), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .re        (re),
      .mem_wen   (mem_wen),
      .mem_waddr (mem_waddr),
      .mem_ren   (mem_ren),
      .mem_raddr (mem_raddr),
      .rd_valid  (rd_valid),
      .full      (full),
      .empty     (empty),
      .afull     (afull),
      .aempty    (aempty),
      .wrcnt     (wrcnt),
      .wptr_gray (wptr_gray),
      .rptr_gray (rptr_gray),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: occupancy and pointers as plain integers, updated on each rising edge.
   int m_cnt, m_w, m_r;
   int m_ov, m_un, m_rv;
   bit started   = 1'b0;
   bit have_prev = 1'b0;
   logic [3:0] prev_wg, prev_rg;

   always @(posedge clk) begin
      int aw, ar;
      if (reset) begin
         m_cnt = 0; m_w = 0; m_r = 0;
         m_ov = 0; m_un = 0; m_rv = 0;
         started   = 1'b1;
         have_prev = 1'b0;
      end else if (started) begin
         aw = (we && m_cnt != DEPTH) ? 1 : 0;
         ar = (re && m_cnt != 0) ? 1 : 0;
         m_ov  = (we && aw == 0) ? 1 : 0;
         m_un  = (re && ar == 0) ? 1 : 0;
         m_rv  = ar;
         m_cnt = m_cnt + aw - ar;
         m_w   = (m_w + aw) % 16;
         m_r   = (m_r + ar) % 16;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("wrcnt",     int'(wrcnt),     m_cnt);
         chk("full",      int'(full),      int'(m_cnt == DEPTH));
         chk("empty",     int'(empty),     int'(m_cnt == 0));
         chk("afull",     int'(afull),     int'(m_cnt >= 6));
         chk("aempty",    int'(aempty),    int'(m_cnt <= 2));
         chk("overflow",  int'(overflow),  m_ov);
         chk("underflow", int'(underflow), m_un);
         chk("rd_valid",  int'(rd_valid),  m_rv);
         chk("wptr_gray", int'(wptr_gray), m_w ^ (m_w >> 1));
         chk("rptr_gray", int'(rptr_gray), m_r ^ (m_r >> 1));
         chk("mem_waddr", int'(mem_waddr), m_w % 8);
         chk("mem_raddr", int'(mem_raddr), m_r % 8);
         chk("mem_wen",   int'(mem_wen),   int'(!reset && we && m_cnt != DEPTH));
         chk("mem_ren",   int'(mem_ren),   int'(!reset && re && m_cnt != 0));
         if (have_prev) begin
            chk("wgray_step", int'($countones(wptr_gray ^ prev_wg) <= 1), 1);
            chk("rgray_step", int'($countones(rptr_gray ^ prev_rg) <= 1), 1);
         end
         prev_wg   = wptr_gray;
         prev_rg   = rptr_gray;
         have_prev = 1'b1;
      end
   end

   // Let the pending inputs take effect at the next edge, then apply new ones.
   task automatic step(input logic w, input logic r, input logic rs);
      @(posedge clk);
      #1;
      we = w; re = r; reset = rs;
      #1;
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; re = 1'b0;
      step(0, 0, 1);
      step(0, 0, 0);
      chk("rst_wrcnt",  int'(wrcnt),  0);
      chk("rst_empty",  int'(empty),  1);
      chk("rst_aempty", int'(aempty), 1);
      chk("rst_full",   int'(full),   0);

      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0);
         chk("fill_waddr", int'(mem_waddr), i);
         chk("fill_wrcnt", int'(wrcnt),     i);
         chk("fill_afull", int'(afull),     int'(i >= 6));
      end

      step(1, 0, 0);
      chk("full_wrcnt", int'(wrcnt),   8);
      chk("full_flag",  int'(full),    1);
      chk("full_afull", int'(afull),   1);
      chk("full_wen",   int'(mem_wen), 0);
      step(0, 0, 0);
      chk("ovf_pulse",  int'(overflow), 1);
      chk("ovf_wrcnt",  int'(wrcnt),    8);
      step(0, 0, 0);
      chk("ovf_clear",  int'(overflow), 0);

      step(1, 1, 0);
      chk("fullrw_wen",   int'(mem_wen),   0);
      chk("fullrw_ren",   int'(mem_ren),   1);
      chk("fullrw_raddr", int'(mem_raddr), 0);
      step(0, 0, 0);
      chk("fullrw_ovf",   int'(overflow), 1);
      chk("fullrw_wrcnt", int'(wrcnt),    7);
      chk("fullrw_full",  int'(full),     0);
      chk("fullrw_rdv",   int'(rd_valid), 1);

      repeat (7) step(0, 1, 0);
      step(0, 1, 0);
      chk("empty_ren", int'(mem_ren), 0);
      step(0, 0, 0);
      chk("unf_pulse", int'(underflow), 1);
      chk("unf_rdv",   int'(rd_valid),  0);

      step(1, 1, 0);
      chk("emptyrw_wen", int'(mem_wen), 1);
      chk("emptyrw_ren", int'(mem_ren), 0);
      step(0, 0, 0);
      chk("emptyrw_unf",   int'(underflow), 1);
      chk("emptyrw_wrcnt", int'(wrcnt),     1);

      repeat (20) step(1, 1, 0);
      step(0, 0, 0);
      chk("stream_wrcnt", int'(wrcnt),     1);
      chk("stream_waddr", int'(mem_waddr), 5);
      chk("stream_wgray", int'(wptr_gray), 11);
      chk("stream_rgray", int'(rptr_gray), 10);

      repeat (4) step(1, 0, 0);
      step(1, 1, 1);
      chk("prerst_wrcnt", int'(wrcnt),   5);
      chk("rst_wen",      int'(mem_wen), 0);
      chk("rst_ren",      int'(mem_ren), 0);
      step(1, 0, 0);
      chk("mid_rst_wrcnt", int'(wrcnt),     0);
      chk("mid_rst_empty", int'(empty),     1);
      chk("mid_rst_aemp",  int'(aempty),    1);
      chk("mid_rst_afull", int'(afull),     0);
      chk("mid_rst_wgray", int'(wptr_gray), 0);
      chk("mid_rst_rgray", int'(rptr_gray), 0);
      chk("mid_rst_rdv",   int'(rd_valid),  0);
      chk("mid_rst_ovf",   int'(overflow),  0);
      chk("mid_rst_unf",   int'(underflow), 0);
      chk("mid_rst_waddr", int'(mem_waddr), 0);
      chk("mid_rst_wen",   int'(mem_wen),   1);
      step(0, 0, 0);
      chk("post_rst_wrcnt", int'(wrcnt), 1);
      step(0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
